ahb3lite_sram_arbiter: RTL and testbench

Two-port arbiter and AHB3-Lite master sequencer placed in front of the `ahb3lite_sram1rw` slave. It accepts simple request/acknowledge transactions from two local requesters and grants the bus round-robin. It drives single NONSEQ transfers (byte, halfword or word) onto the AHB3-Lite bus, tracks slave wait states and error responses, and returns read data and status to the granted requester.

---
 rtl/ahb3lite_sram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ahb3lite_sram_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_arbiter.sv
// ahb3lite_sram_arbiter: round-robin two-port front end that
// sequences single NONSEQ AHB3-Lite transfers to an SRAM slave.
module ahb3lite_sram_arbiter #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [2:0]            size0_i,
  input  logic [2:0]            size1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [1:0]            ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADYOUT,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_MISALIGN
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hsel_q, hsel_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [1:0]            ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]            elig;
  logic                  grant;
  logic                  pick;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_size;
  logic [DATA_WIDTH-1:0] sel_wdata;

  function automatic logic misaligned(
    input logic [2:0] sz,
    input logic [1:0] lo
  );
    logic bad;
    unique case (sz)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lo[0];
      3'b010:  bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // A requester whose ack is showing this cycle is finishing, not asking.
  assign elig = req_i & ~ack_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    wdata_d  = wdata_q;
    hsel_d   = hsel_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    htrans_d = htrans_q;
    ack_d    = 2'b00;
    err_d    = err_q;
    rdata_d  = rdata_q;
    grant    = 1'b0;
    pick     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|elig) begin
          grant = 1'b1;
          pick  = (&elig) ? ~last_q : elig[1];
        end
      end
      S_ADDR: begin
        state_d  = S_DATA;
        hsel_d   = 1'b0;
        htrans_d = HT_IDLE;
        hwdata_d = wdata_q;
      end
      S_DATA: begin
        if (HREADYOUT) begin
          ack_d[owner_q] = 1'b1;
          err_d          = HRESP;
          rdata_d        = HRDATA;
          state_d        = S_IDLE;
          if (elig[~owner_q]) begin
            grant = 1'b1;
            pick  = ~owner_q;
          end
        end
      end
      S_MISALIGN: begin
        ack_d[owner_q] = 1'b1;
        err_d          = 1'b1;
        rdata_d        = '0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sel_we    = pick ? we_i[1]  : we_i[0];
    sel_addr  = pick ? addr1_i  : addr0_i;
    sel_size  = pick ? size1_i  : size0_i;
    sel_wdata = pick ? wdata1_i : wdata0_i;

    if (grant) begin
      owner_d = pick;
      last_d  = pick;
      wdata_d = sel_wdata;
      if (misaligned(sel_size, sel_addr[1:0])) begin
        state_d = S_MISALIGN;
      end else begin
        state_d  = S_ADDR;
        hsel_d   = 1'b1;
        htrans_d = HT_NONSEQ;
        haddr_d  = sel_addr;
        hwrite_d = sel_we;
        hsize_d  = sel_size;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      wdata_q  <= '0;
      hsel_q   <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
      htrans_q <= HT_IDLE;
      ack_q    <= 2'b00;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      wdata_q  <= wdata_d;
      hsel_q   <= hsel_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      htrans_q <= htrans_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign HSEL    = hsel_q;
  assign HADDR   = haddr_q;
  assign HWDATA  = hwdata_q;
  assign HWRITE  = hwrite_q;
  assign HSIZE   = hsize_q;
  assign HTRANS  = htrans_q;
  assign HBURST  = 3'b000;
  assign HPROT   = HPROT_VAL;
  assign HREADY  = HREADYOUT;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Bench for ahb3lite_sram_arbiter: scripted requesters and slave,
// with bus-transfer and ack scoreboards checked per scenario.
module tb_ahb3lite_sram_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  req_i, we_i;
  logic [31:0] addr0_i, addr1_i;
  logic [2:0]  size0_i, size1_i;
  logic [31:0] wdata0_i, wdata1_i;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        HSEL;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;

  ahb3lite_sram_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .size0_i(size0_i), .size1_i(size1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_t;

  ack_t exp_ack[$];
  ack_t obs_ack[$];
  bus_t exp_bus[$];
  bus_t obs_bus[$];
  int   ack_rd, bus_rd;
  int   total, bad;
  int   left [2];

  logic [31:0] cyc = 32'd0;
  bus_t        ns_pend;
  bit          ns_seen = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 32'd1;

  // Log each NONSEQ together with the HWDATA of its data phase, and every ack.
  always @(negedge HCLK) begin
    if (ns_seen) begin
      ns_pend.wdata = HWDATA;
      obs_bus.push_back(ns_pend);
    end
    ns_seen = (HTRANS == 2'b10);
    if (ns_seen) ns_pend = {cyc, HADDR, HWRITE, HSIZE, 32'h0};
    if (ack_o != 2'b00) obs_ack.push_back({cyc, ack_o, err_o, rdata_o});
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic run(input int n, output bit late);
    int got0;
    got0 = obs_ack.size();
    late = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (obs_ack.size() - got0 >= n) begin
        late = 1'b0;
        break;
      end
      tick();
      for (int r = 0; r < 2; r++) begin
        if (req_i[r] && ack_o[r]) begin
          req_i[r] = 1'b0;
          left[r]--;
        end else if (!req_i[r] && left[r] > 0) begin
          req_i[r] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    req_i = 2'b11; we_i = 2'b11;
    addr0_i = 32'h44; addr1_i = 32'h88;
    size0_i = 3'b010; size1_i = 3'b010;
    wdata0_i = 32'hAAAA5555; wdata1_i = 32'h5555AAAA;
    HRDATA = 32'h0; HREADYOUT = 1'b1; HRESP = 1'b0;
    tick();
    tick();
    total++;
    if ({HSEL, HTRANS, HADDR, HWDATA, HWRITE, HSIZE, ack_o, err_o, rdata_o} !== 106'h0) begin
      bad++;
      $display("FAIL reset_outputs got sel=%b tr=%b a=%h d=%h w=%b s=%b ack=%b err=%b rd=%h want all zero",
               HSEL, HTRANS, HADDR, HWDATA, HWRITE, HSIZE, ack_o, err_o, rdata_o);
    end
    total++;
    if ({HBURST, HPROT} !== 7'b000_0011) begin
      bad++;
      $display("FAIL reset_consts got burst=%b prot=%b want 000 0011", HBURST, HPROT);
    end
    total++;
    if (HREADY !== 1'b1) begin
      bad++;
      $display("FAIL hready_hi got=%b want=1", HREADY);
    end
    HREADYOUT = 1'b0;
    #1;
    total++;
    if (HREADY !== 1'b0) begin
      bad++;
      $display("FAIL hready_lo got=%b want=0", HREADY);
    end
    HREADYOUT = 1'b1;
    req_i = 2'b00;
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_word_write;
    logic [31:0] t0;
    bit late;
    bus_t eb, ob;
    ack_t ea, oa;
    HRDATA = 32'h0BADF00D;
    t0 = cyc;
    we_i = 2'b01; addr0_i = 32'h10; size0_i = 3'b010;
    wdata0_i = 32'hDEADBEEF;
    req_i = 2'b01; left[0] = 1;
    exp_bus.push_back({t0 + 32'd1, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF});
    exp_ack.push_back({t0 + 32'd3, 2'b01, 1'b0, 32'h0BADF00D});
    run(1, late);
    total++;
    if (late) begin
      bad++;
      $display("FAIL word_timeout got no ack want ack within budget");
    end
    while (exp_bus.size() != 0) begin
      eb = exp_bus.pop_front();
      ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++;
      total++;
      if (ob !== eb) begin
        bad++;
        $display("FAIL word_bus got cyc=%0d a=%h w=%b s=%b d=%h want cyc=%0d a=%h w=%b s=%b d=%h",
                 ob.cyc, ob.addr, ob.wr, ob.size, ob.wdata, eb.cyc, eb.addr, eb.wr, eb.size, eb.wdata);
      end
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = '0;
      if (ack_rd < obs_ack.size()) oa = obs_ack[ack_rd];
      ack_rd++;
      total++;
      if (oa !== ea) begin
        bad++;
        $display("FAIL word_ack got cyc=%0d ack=%b err=%b rd=%h want cyc=%0d ack=%b err=%b rd=%h",
                 oa.cyc, oa.ack, oa.err, oa.rdata, ea.cyc, ea.ack, ea.err, ea.rdata);
      end
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] t0;
    bit late;
    bus_t eb, ob;
    ack_t ea, oa;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    HRDATA = 32'h0;
    t0 = cyc;
    we_i = 2'b11;
    addr0_i = 32'h20; addr1_i = 32'h24;
    size0_i = 3'b010; size1_i = 3'b010;
    wdata0_i = 32'h11110000; wdata1_i = 32'h22220000;
    req_i = 2'b11; left[0] = 2; left[1] = 2;
    for (int k = 0; k < 4; k++) begin
      exp_bus.push_back({t0 + 32'(2 * k + 1), (k % 2 == 0) ? 32'h20 : 32'h24,
                         1'b1, 3'b010, (k % 2 == 0) ? 32'h11110000 : 32'h22220000});
      exp_ack.push_back({t0 + 32'(2 * k + 3), (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 32'h0});
    end
    run(4, late);
    total++;
    if (late) begin
      bad++;
      $display("FAIL arb_timeout got %0d acks want 4", obs_ack.size() - ack_rd);
    end
    while (exp_bus.size() != 0) begin
      eb = exp_bus.pop_front();
      ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++;
      total++;
      if (ob !== eb) begin
        bad++;
        $display("FAIL arb_bus got cyc=%0d a=%h w=%b s=%b d=%h want cyc=%0d a=%h w=%b s=%b d=%h",
                 ob.cyc, ob.addr, ob.wr, ob.size, ob.wdata, eb.cyc, eb.addr, eb.wr, eb.size, eb.wdata);
      end
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = '0;
      if (ack_rd < obs_ack.size()) oa = obs_ack[ack_rd];
      ack_rd++;
      total++;
      if (oa !== ea) begin
        bad++;
        $display("FAIL arb_ack got cyc=%0d ack=%b err=%b rd=%h want cyc=%0d ack=%b err=%b rd=%h",
                 oa.cyc, oa.ack, oa.err, oa.rdata, ea.cyc, ea.ack, ea.err, ea.rdata);
      end
    end
  endtask

  task automatic test_wait_read;
    logic [31:0] t0;
    bit late;
    bus_t eb, ob;
    ack_t ea, oa;
    HRDATA = 32'hDEADBEEF;
    t0 = cyc;
    we_i = 2'b00; addr1_i = 32'h10; size1_i = 3'b010;
    wdata1_i = 32'h5A5A5A5A;
    req_i = 2'b10; left[1] = 1;
    exp_bus.push_back({t0 + 32'd1, 32'h10, 1'b0, 3'b010, 32'h5A5A5A5A});
    exp_ack.push_back({t0 + 32'd5, 2'b10, 1'b0, 32'hDEADBEEF});
    tick();
    tick();
    HREADYOUT = 1'b0;
    for (int w = 0; w < 3; w++) begin
      if (w == 2) HREADYOUT = 1'b1;
      total++;
      if ({HSEL, HTRANS, HWDATA, ack_o} !== {1'b0, 2'b00, 32'h5A5A5A5A, 2'b00}) begin
        bad++;
        $display("FAIL wait_hold[%0d] got sel=%b tr=%b d=%h ack=%b want sel=0 tr=00 d=5a5a5a5a ack=00",
                 w, HSEL, HTRANS, HWDATA, ack_o);
      end
      if (w < 2) tick();
    end
    run(1, late);
    total++;
    if (late) begin
      bad++;
      $display("FAIL wait_timeout got no ack want ack within budget");
    end
    while (exp_bus.size() != 0) begin
      eb = exp_bus.pop_front();
      ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++;
      total++;
      if (ob !== eb) begin
        bad++;
        $display("FAIL wait_bus got cyc=%0d a=%h w=%b s=%b d=%h want cyc=%0d a=%h w=%b s=%b d=%h",
                 ob.cyc, ob.addr, ob.wr, ob.size, ob.wdata, eb.cyc, eb.addr, eb.wr, eb.size, eb.wdata);
      end
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = '0;
      if (ack_rd < obs_ack.size()) oa = obs_ack[ack_rd];
      ack_rd++;
      total++;
      if (oa !== ea) begin
        bad++;
        $display("FAIL wait_ack got cyc=%0d ack=%b err=%b rd=%h want cyc=%0d ack=%b err=%b rd=%h",
                 oa.cyc, oa.ack, oa.err, oa.rdata, ea.cyc, ea.ack, ea.err, ea.rdata);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] t0;
    bit late;
    bus_t eb, ob;
    ack_t ea, oa;
    logic [1:0]  mr [3];
    logic [2:0]  ms [3];
    logic [31:0] ma [3];
    mr[0] = 2'b01; ms[0] = 3'b001; ma[0] = 32'h3;
    mr[1] = 2'b10; ms[1] = 3'b011; ma[1] = 32'h8;
    mr[2] = 2'b10; ms[2] = 3'b010; ma[2] = 32'h2;
    HRDATA = 32'h11112222;
    t0 = cyc;
    we_i = 2'b00; addr0_i = 32'h40; size0_i = 3'b010; wdata0_i = 32'h0;
    req_i = 2'b01; left[0] = 1;
    exp_bus.push_back({t0 + 32'd1, 32'h40, 1'b0, 3'b010, 32'h0});
    exp_ack.push_back({t0 + 32'd4, 2'b01, 1'b1, 32'h11112222});
    tick();
    tick();
    HREADYOUT = 1'b0; HRESP = 1'b1;
    tick();
    HREADYOUT = 1'b1;
    run(1, late);
    HRESP = 1'b0;
    total++;
    if (late) begin
      bad++;
      $display("FAIL hresp_timeout got no ack want ack within budget");
    end
    for (int m = 0; m < 3; m++) begin
      t0 = cyc;
      we_i = 2'b11;
      addr0_i = ma[m]; addr1_i = ma[m];
      size0_i = ms[m]; size1_i = ms[m];
      req_i = mr[m];
      left[0] = mr[m][0] ? 1 : 0;
      left[1] = mr[m][1] ? 1 : 0;
      exp_ack.push_back({t0 + 32'd2, mr[m], 1'b1, 32'h0});
      run(1, late);
      total++;
      if (late) begin
        bad++;
        $display("FAIL misalign_timeout[%0d] got no ack want ack within budget", m);
      end
    end
    while (exp_bus.size() != 0) begin
      eb = exp_bus.pop_front();
      ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++;
      total++;
      if (ob !== eb) begin
        bad++;
        $display("FAIL err_bus got cyc=%0d a=%h w=%b s=%b d=%h want cyc=%0d a=%h w=%b s=%b d=%h",
                 ob.cyc, ob.addr, ob.wr, ob.size, ob.wdata, eb.cyc, eb.addr, eb.wr, eb.size, eb.wdata);
      end
    end
    total++;
    if (obs_bus.size() != bus_rd) begin
      bad++;
      $display("FAIL misalign_no_bus got transfers=%0d want=%0d", obs_bus.size(), bus_rd);
      bus_rd = obs_bus.size();
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = '0;
      if (ack_rd < obs_ack.size()) oa = obs_ack[ack_rd];
      ack_rd++;
      total++;
      if (oa !== ea) begin
        bad++;
        $display("FAIL err_ack got cyc=%0d ack=%b err=%b rd=%h want cyc=%0d ack=%b err=%b rd=%h",
                 oa.cyc, oa.ack, oa.err, oa.rdata, ea.cyc, ea.ack, ea.err, ea.rdata);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] t0;
    bit late;
    bus_t eb, ob;
    ack_t ea, oa;
    HRDATA = 32'hCAFE0001;
    t0 = cyc;
    we_i = 2'b01; addr0_i = 32'h50; size0_i = 3'b010; wdata0_i = 32'h77;
    req_i = 2'b01; left[0] = 1;
    exp_bus.push_back({t0 + 32'd1, 32'h50, 1'b1, 3'b010, 32'h77});
    tick();
    tick();
    HREADYOUT = 1'b0;
    HRESET = 1'b1;
    tick();
    total++;
    if ({HSEL, HTRANS, HADDR, HWDATA, HWRITE, HSIZE, ack_o, err_o, rdata_o} !== 106'h0) begin
      bad++;
      $display("FAIL midreset_outputs got sel=%b tr=%b a=%h d=%h w=%b s=%b ack=%b err=%b rd=%h want all zero",
               HSEL, HTRANS, HADDR, HWDATA, HWRITE, HSIZE, ack_o, err_o, rdata_o);
    end
    req_i = 2'b00; left[0] = 0;
    HRESET = 1'b0;
    HREADYOUT = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (obs_ack.size() != ack_rd) begin
      bad++;
      $display("FAIL midreset_no_ack got acks=%0d want=%0d", obs_ack.size(), ack_rd);
      ack_rd = obs_ack.size();
    end
    t0 = cyc;
    addr0_i = 32'h60; wdata0_i = 32'h88;
    req_i = 2'b01; left[0] = 1;
    exp_bus.push_back({t0 + 32'd1, 32'h60, 1'b1, 3'b010, 32'h88});
    exp_ack.push_back({t0 + 32'd3, 2'b01, 1'b0, 32'hCAFE0001});
    run(1, late);
    total++;
    if (late) begin
      bad++;
      $display("FAIL post_reset_timeout got no ack want ack within budget");
    end
    while (exp_bus.size() != 0) begin
      eb = exp_bus.pop_front();
      ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++;
      total++;
      if (ob !== eb) begin
        bad++;
        $display("FAIL mid_bus got cyc=%0d a=%h w=%b s=%b d=%h want cyc=%0d a=%h w=%b s=%b d=%h",
                 ob.cyc, ob.addr, ob.wr, ob.size, ob.wdata, eb.cyc, eb.addr, eb.wr, eb.size, eb.wdata);
      end
    end
    while (exp_ack.size() != 0) begin
      ea = exp_ack.pop_front();
      oa = '0;
      if (ack_rd < obs_ack.size()) oa = obs_ack[ack_rd];
      ack_rd++;
      total++;
      if (oa !== ea) begin
        bad++;
        $display("FAIL mid_ack got cyc=%0d ack=%b err=%b rd=%h want cyc=%0d ack=%b err=%b rd=%h",
                 oa.cyc, oa.ack, oa.err, oa.rdata, ea.cyc, ea.ack, ea.err, ea.rdata);
      end
    end
    total++;
    if (obs_ack.size() != ack_rd) begin
      bad++;
      $display("FAIL final_ack_count got=%0d want=%0d", obs_ack.size(), ack_rd);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    ack_rd = 0; bus_rd = 0;
    left[0] = 0; left[1] = 0;
    test_reset();
    test_word_write();
    test_arbitration();
    test_wait_read();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
